// File: rtl/i2c_rx_pkg.sv
// i2c_rx_pkg: shared receive-path state encodings and constants for the i2c_rx block.
package i2c_rx_pkg;
  typedef enum logic [2:0] {RX_IDLE, RX_BITLO, RX_BITHI, RX_ACKLO, RX_ACKHI} rx_state_e;
  localparam int TQ = 1;
  localparam logic [6:0] SLAVE_ADDR_DEF = 7'h50;
endpackage

// File: rtl/i2c_rx_shift.sv
// i2c_rx_shift: MSB-first 8-bit shift register with 3-bit bit counter.
module i2c_rx_shift (
  input  logic       clk,
  input  logic       rst_an,
  input  logic       shift_i,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic       bit_i,
  output logic [7:0] data_o,
  output logic [2:0] cnt_o
);
  logic [7:0] data_q, data_d;
  logic [2:0] cnt_q, cnt_d;
  assign data_d = clr_i ? 8'h00 : shift_i ? {data_q[6:0], bit_i} : data_q;
  assign cnt_d  = clr_i ? 3'd0 : inc_i ? cnt_q + 3'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_an)
    if (!rst_an) begin
      data_q <= 8'h00;
      cnt_q  <= 3'd0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  assign data_o = data_q;
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/i2c_rx.sv
// i2c_rx: I2C serial-to-parallel receiver with ACK/NACK drive and START/STOP tracking.
// Optional address filtering on the first byte after START when I2C_RX_ADDR_MATCH_EN is defined.
module i2c_rx
  import i2c_rx_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEF,
  parameter int         FILTER_LEN = 2
) (
  input  logic       clk,
  input  logic       rst_an,
  input  logic       enable,
  input  logic       ackEnable,
  input  logic       sclLevel,
  input  logic       sclRise,
  input  logic       sclFall,
  input  logic       sdaIn,
  input  logic       startDet,
  input  logic       stopDet,
  output logic       sdaOut,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       busy,
  output logic       addrMatch
);
  localparam int CW = FILTER_LEN > 0 ? $clog2(FILTER_LEN + 1) : 1;
  rx_state_e  state_q, state_d;
  logic       sda_q, sda_d, valid_q, valid_d, busy_q, busy_d;
  logic [7:0] data_q, data_d, sh;
  logic [2:0] cnt;
  logic       shift, clr, inc, sda_f;
  logic       scl_unused;
  assign scl_unused = sclLevel;
  if (FILTER_LEN > 0) begin : g_filt
    logic          cand_q, filt_q;
    logic [CW-1:0] stab_q;
    always_ff @(posedge clk or negedge rst_an)
      if (!rst_an) begin
        cand_q <= 1'b1;
        stab_q <= CW'(FILTER_LEN);
        filt_q <= 1'b1;
      end else begin
        cand_q <= sdaIn;
        stab_q <= (sdaIn != cand_q) ? CW'(1) : (stab_q < CW'(FILTER_LEN)) ? stab_q + CW'(1) : stab_q;
        if (stab_q == CW'(FILTER_LEN)) filt_q <= cand_q;
      end
    assign sda_f = filt_q;
  end else begin : g_nofilt
    assign sda_f = sdaIn;
  end
  i2c_rx_shift u_shift (
    .clk    (clk),
    .rst_an (rst_an),
    .shift_i(shift),
    .clr_i  (clr),
    .inc_i  (inc),
    .bit_i  (sda_f),
    .data_o (sh),
    .cnt_o  (cnt)
  );
`ifdef I2C_RX_ADDR_MATCH_EN
  logic addr_q, addr_d, match_q, match_d;
`else
  logic [6:0] addr_unused;
  assign addr_unused = SLAVE_ADDR;
`endif
  always_comb begin
    state_d = state_q;
    sda_d   = sda_q;
    data_d  = data_q;
    valid_d = 1'b0;
    shift   = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
`ifdef I2C_RX_ADDR_MATCH_EN
    addr_d  = addr_q;
    match_d = match_q;
`endif
    if (!enable) begin
      state_d = RX_IDLE;
      sda_d   = 1'b1;
    end else if (stopDet) begin
      state_d = RX_IDLE;
      sda_d   = 1'b1;
      clr     = 1'b1;
`ifdef I2C_RX_ADDR_MATCH_EN
      match_d = 1'b0;
`endif
    end else if (startDet) begin
      state_d = RX_BITLO;
      sda_d   = 1'b1;
      clr     = 1'b1;
`ifdef I2C_RX_ADDR_MATCH_EN
      addr_d  = 1'b1;
`endif
    end else begin
      case (state_q)
        RX_BITLO: if (sclRise) begin
          shift   = 1'b1;
          state_d = RX_BITHI;
        end
        RX_BITHI: if (sclFall && !sclRise) begin
          if (cnt == 3'd7) begin
            data_d  = sh;
            valid_d = 1'b1;
            sda_d   = !ackEnable;
            state_d = RX_ACKLO;
`ifdef I2C_RX_ADDR_MATCH_EN
            if (addr_q) begin
              addr_d  = 1'b0;
              match_d = sh[7:1] == SLAVE_ADDR;
              // a foreign address leaves the bus alone until the next START
              if (!match_d) begin
                data_d  = data_q;
                valid_d = 1'b0;
                sda_d   = 1'b1;
                state_d = RX_IDLE;
              end
            end
`endif
          end else begin
            inc     = 1'b1;
            state_d = RX_BITLO;
          end
        end
        RX_ACKLO: if (sclRise) state_d = RX_ACKHI;
        RX_ACKHI: if (sclFall && !sclRise) begin
          sda_d   = 1'b1;
          clr     = 1'b1;
          state_d = RX_BITLO;
        end
        default: state_d = RX_IDLE;
      endcase
    end
    busy_d = state_d != RX_IDLE;
  end
  always_ff @(posedge clk or negedge rst_an)
    if (!rst_an) begin
      state_q <= RX_IDLE;
      sda_q   <= 1'b1;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sda_q   <= sda_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
`ifdef I2C_RX_ADDR_MATCH_EN
  always_ff @(posedge clk or negedge rst_an)
    if (!rst_an) begin
      addr_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      match_q <= match_d;
    end
  assign addrMatch = match_q;
`else
  assign addrMatch = 1'b1;
`endif
  assign sdaOut  = sda_q;
  assign rxData  = data_q;
  assign rxValid = valid_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_i2c_rx.sv
// tb_i2c_rx: randomized scoreboard bench for i2c_rx against a byte-level reference model.
module tb_i2c_rx;
  import i2c_rx_pkg::*;
  logic clk = 1'b0, rst_an = 1'b0, enable = 1'b0, ackEnable = 1'b1, sclLevel = 1'b1;
  logic sclRise = 1'b0, sclFall = 1'b0, sdaIn = 1'b1, startDet = 1'b0, stopDet = 1'b0;
  logic sdaOut, rxValid, busy, addrMatch;
  logic [7:0] rxData;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic ign = 1'b0, addr_ph = 1'b0;
`ifdef I2C_RX_ADDR_MATCH_EN
  logic exp_match = 1'b0;
`else
  logic exp_match = 1'b1;
`endif

  always #5 clk = ~clk;

  i2c_rx dut (
    .clk(clk), .rst_an(rst_an), .enable(enable), .ackEnable(ackEnable), .sclLevel(sclLevel),
    .sclRise(sclRise), .sclFall(sclFall), .sdaIn(sdaIn), .startDet(startDet), .stopDet(stopDet),
    .sdaOut(sdaOut), .rxData(rxData), .rxValid(rxValid), .busy(busy), .addrMatch(addrMatch)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_an && rxValid) begin
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected rxValid: got data %h expected no byte at %0t", rxData, $time);
    end else begin
      last_data = exp_q.pop_front();
      chk("rxData", rxData, last_data);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #TQ; end
  endtask

  task automatic rise();
    sclRise = 1'b1; sclLevel = 1'b1; tick(); sclRise = 1'b0; tick(3);
  endtask

  task automatic fall();
    sclFall = 1'b1; sclLevel = 1'b0; tick(); sclFall = 1'b0; tick(2);
  endtask

  task automatic put_bit(input logic b, input logic glitch = 1'b0);
    sdaIn = b;
    tick(4);
    if (glitch) begin sdaIn = !b; tick(); sdaIn = b; tick(4); end
    rise();
    fall();
  endtask

  task automatic do_start();
    startDet = 1'b1; tick(); startDet = 1'b0; tick();
    addr_ph = 1'b1; ign = 1'b0;
  endtask

  task automatic do_stop();
    stopDet = 1'b1; tick(); stopDet = 1'b0;
`ifdef I2C_RX_ADDR_MATCH_EN
    exp_match = 1'b0;
`endif
    ign = 1'b1;
    chk("busy after stop", busy, 0);
    chk("sdaOut after stop", sdaOut, 1);
    chk("addrMatch after stop", addrMatch, exp_match);
    tick();
  endtask

  // Eight data bits; leaves the bench in the ACK low phase.
  task automatic send_bits(input logic [7:0] b, input logic ack, input logic glitch = 1'b0);
    logic push, acked;
    push = !ign;
`ifdef I2C_RX_ADDR_MATCH_EN
    if (push && addr_ph) begin
      addr_ph = 1'b0;
      exp_match = b[7:1] == 7'h50;
      if (!exp_match) begin push = 1'b0; ign = 1'b1; end
    end
`endif
    acked = push && ack;
    ackEnable = ack;
    if (push) exp_q.push_back(b);
    for (int i = 7; i >= 0; i--) put_bit(b[i], glitch && i == 3);
    chk("ack drive", sdaOut, !acked);
    chk("addrMatch", addrMatch, exp_match);
  endtask

  task automatic ack_clk();
    logic s;
    s = sdaOut;
    sdaIn = 1'b1;
    tick(4);
    rise();
    chk("ack hold", sdaOut, s);
    fall();
    chk("ack release", sdaOut, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack, input logic glitch = 1'b0);
    send_bits(b, ack, glitch);
    ack_clk();
  endtask

  task automatic partial(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) put_bit(b[7 - i]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int nb;
    tick(2);
    chk("reset sdaOut", sdaOut, 1);
    chk("reset rxData", rxData, 8'h00);
    chk("reset rxValid", rxValid, 0);
    chk("reset busy", busy, 0);
    chk("reset addrMatch", addrMatch, exp_match);
    rst_an = 1'b1; enable = 1'b1;
    tick(5);
    // directed: ACKed byte, NACKed byte
    do_start();
    chk("busy after start", busy, 1);
    send_byte(8'hA0, 1);
    send_byte(8'hA5, 1);
    send_byte(8'hA5, 0, 1'b1);
    do_stop();
    // stop after four bits
    do_start();
    send_byte(8'hA1, 1);
    partial(8'hF0, 4);
    do_stop();
    chk("rxData after abort", rxData, last_data);
    // repeated start after five bits, then 3C
    do_start();
    send_byte(8'hA0, 1);
    partial(8'h77, 5);
    do_start();
    send_byte(8'hA0, 1);
    send_byte(8'h3C, 1);
    do_stop();
    // address mismatch then data
    do_start();
    send_byte(8'hA2, 1);
    send_byte(8'h11, 1);
    do_stop();
    // enable dropped mid-byte and mid-ACK
    do_start();
    send_byte(8'hA0, 1);
    partial(8'hC3, 3);
    enable = 1'b0; tick();
    chk("busy enable off", busy, 0);
    chk("sdaOut enable off", sdaOut, 1);
    enable = 1'b1;
    do_start();
    send_byte(8'hA0, 1);
    send_bits(8'h5A, 1);
    enable = 1'b0; tick();
    chk("sdaOut enable off ack", sdaOut, 1);
    chk("busy enable off ack", busy, 0);
    enable = 1'b1;
    do_stop();
    // random transactions
    for (int t = 0; t < 30; t++) begin
      do_start();
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        if (k == 0 && $urandom_range(0, 1) == 1) b[7:1] = 7'h50;
        send_byte(b, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0) begin
        partial(8'($urandom), $urandom_range(1, 7));
        if ($urandom_range(0, 1) == 1) begin
          do_start();
          send_byte({7'h50, 1'($urandom)}, 1);
          send_byte(8'($urandom), 1'($urandom_range(0, 1)));
        end
      end
      do_stop();
    end
    // asynchronous reset while ACK is being driven
    do_start();
    send_byte(8'hA0, 1);
    send_bits(8'h77, 1);
    #2 rst_an = 1'b0;
    #1;
    chk("async sdaOut", sdaOut, 1);
    chk("async rxData", rxData, 8'h00);
    chk("async rxValid", rxValid, 0);
    chk("async busy", busy, 0);
`ifdef I2C_RX_ADDR_MATCH_EN
    exp_match = 1'b0;
`endif
    chk("async addrMatch", addrMatch, exp_match);
    tick(3);
    rst_an = 1'b1;
    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing rxValid: got %0d outstanding bytes expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
